// File: rtl/sram_timing_ctrl.sv
// sram_timing_ctrl: programmable precharge/wordline/sense phase sequencer for one SRAM access
//   clk                    rising-edge clock
//   rst                    asynchronous active-low reset
//   start                  access request, sampled only in IDLE
//   pc/wl/sae_cycles       phase lengths in cycles (0 behaves as 1)
//   pc_b, wl_en, sae       phase drivers (pc_b active-low)
//   busy, done             access in flight / one-cycle end-of-access pulse
//   abort, aborted         present only with SRAM_TIMING_ABORT_EN defined
module sram_timing_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pc_cycles,
  input  logic [WIDTH-1:0] wl_cycles,
  input  logic [WIDTH-1:0] sae_cycles,
`ifdef SRAM_TIMING_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             pc_b,
  output logic             wl_en,
  output logic             sae,
  output logic             busy,
  output logic             done
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_WL    = 3'd2;
  localparam logic [2:0] S_SENSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]       r_state, w_next;
  logic [WIDTH-1:0] r_cnt, w_cnt, r_wl, r_sae, w_wl, w_sae;
  logic             r_pc_b, r_wl_en, r_sae_en, r_busy, r_done;
  // counter load value: a zero length still gives one cycle
  function automatic logic [WIDTH-1:0] eff_m1(input logic [WIDTH-1:0] x);
    return (x == '0) ? '0 : x - WIDTH'(1);
  endfunction
`ifdef SRAM_TIMING_ABORT_EN
  logic w_abort, r_aborted;
  assign w_abort = abort && (r_state == S_PRE || r_state == S_WL || r_state == S_SENSE);
  assign aborted = r_aborted;
`endif
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_wl   = r_wl;
    w_sae  = r_sae;
    case (r_state)
      S_IDLE: if (start) begin
        w_next = S_PRE;
        w_cnt  = eff_m1(pc_cycles);
        w_wl   = wl_cycles;
        w_sae  = sae_cycles;
      end
      S_PRE, S_WL, S_SENSE: if (r_cnt != '0) w_cnt = r_cnt - WIDTH'(1);
      else begin
        w_next = (r_state == S_PRE) ? S_WL : (r_state == S_WL) ? S_SENSE : S_DONE;
        w_cnt  = (r_state == S_PRE) ? eff_m1(r_wl) : (r_state == S_WL) ? eff_m1(r_sae) : '0;
      end
      default: w_next = S_IDLE;
    endcase
`ifdef SRAM_TIMING_ABORT_EN
    // abort wins over counter expiry
    if (w_abort) begin
      w_next = S_IDLE;
      w_cnt  = '0;
    end
`endif
  end
  // outputs are registered from the next state so they line up with r_state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wl     <= '0;
      r_sae    <= '0;
      r_pc_b   <= 1'b1;
      r_wl_en  <= 1'b0;
      r_sae_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_wl     <= w_wl;
      r_sae    <= w_sae;
      r_pc_b   <= w_next != S_PRE;
      r_wl_en  <= w_next == S_WL;
      r_sae_en <= w_next == S_SENSE;
      r_busy   <= w_next != S_IDLE;
      r_done   <= w_next == S_DONE;
    end
  end
`ifdef SRAM_TIMING_ABORT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_aborted <= 1'b0;
    else r_aborted <= w_abort;
  end
`endif
  assign pc_b  = r_pc_b;
  assign wl_en = r_wl_en;
  assign sae   = r_sae_en;
  assign busy  = r_busy;
  assign done  = r_done;
endmodule

// File: doc/sram_timing_ctrl.md
Name: sram_timing_ctrl

Overview:
Phase sequencer for one SRAM access. It runs an internal WIDTH-bit down-counter through three programmable phases: precharge, wordline and sense-enable. A done pulse marks the end of the access. It sits between the SRAM control logic and the array peripheral drivers, and replaces fixed delay chains with cycle-programmable timing.

Parameters:
WIDTH, 12, width of each phase-duration input and of the internal phase counter.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
start  input  1  access request; sampled only in IDLE.
pc_cycles  input  WIDTH  precharge phase length in cycles.
wl_cycles  input  WIDTH  wordline phase length in cycles.
sae_cycles  input  WIDTH  sense-enable phase length in cycles.
pc_b  output  1  precharge enable, active-low.
wl_en  output  1  wordline enable.
sae  output  1  sense-amp enable.
busy  output  1  high from the first phase cycle through the DONE cycle.
done  output  1  one-cycle pulse at the end of an access.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, pc_b=1, wl_en=0, sae=0, busy=0, done=0. Reset mid-access aborts immediately and produces no done pulse.
- All outputs are registered, decoded from the state register; there are no combinational paths from inputs to outputs.
- States: IDLE, PRE, WL, SENSE, DONE.
- Output decode per state:
  - IDLE: pc_b=1, wl_en=0, sae=0, busy=0, done=0.
  - PRE: pc_b=0, busy=1.
  - WL: wl_en=1, busy=1.
  - SENSE: sae=1, busy=1.
  - DONE: done=1, busy=1.
  - At most one of {pc_b low, wl_en, sae, done} is active in any cycle.
- IDLE with start=1 at an edge: capture all three cycle inputs into internal registers, go to PRE, load counter = eff(pc)-1.
- Effective length: eff(x) = (x==0) ? 1 : x. A zero length yields one cycle, never a skipped phase.
- In PRE, WL or SENSE:
  - counter != 0: decrement.
  - counter == 0: advance PRE->WL (load eff(wl)-1), WL->SENSE (load eff(sae)-1), SENSE->DONE.
- DONE -> IDLE unconditionally after one cycle.
- start is ignored in PRE, WL, SENSE and DONE; it is not queued.
- Changing the cycle inputs during an access has no effect; the captured values are used.
- Back-to-back accesses: start held high gives a new access every eff(pc)+eff(wl)+eff(sae)+2 cycles (one IDLE cycle between accesses).
- Timing from the start-sampling edge E0:
  - pc_b low for cycles 1..P.
  - wl_en high for P+1..P+W.
  - sae high for P+W+1..P+W+S.
  - done at P+W+S+1.
  - Here P, W, S are the effective lengths.
- Counter width WIDTH; maximum phase length 2^WIDTH-1 cycles; no wrap-around is possible because the counter only decrements to 0.

Optional Feature:
- Macro SRAM_TIMING_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 at an edge in PRE, WL or SENSE: next state IDLE, all phase outputs return to idle values, no done pulse, aborted=1 for exactly one cycle.
  - abort in IDLE or DONE is ignored, and DONE still completes.
  - abort has priority over counter expiry in the same cycle.
- When undefined: no abort/aborted ports, no related logic, and behaviour is exactly as specified above.

Test Plan:
- Reset check: hold rst=0 for 4 cycles -> pc_b=1, wl_en=0, sae=0, busy=0, done=0; release rst with start=0 for 16 cycles -> outputs unchanged.
- Nominal access: pc=2, wl=3, sae=1, start pulse at E0 -> pc_b low cycles 1-2, wl_en 3-5, sae 6, done 7, busy 1-7, IDLE at 8.
- Zero lengths: pc=0, wl=0, sae=0 -> each phase lasts exactly 1 cycle; done at cycle 4.
- Ignore and capture: start held high with wl changed from 3 to 10 mid-access -> first access uses wl=3; next access begins 1 cycle after done with wl=10; exactly one done per access.
- Async reset mid-WL: assert rst=0 between clock edges during wl_en=1 -> wl_en drops without waiting for a clock edge, done never pulses, and a fresh start after release runs normally.
- SRAM_TIMING_ABORT_EN defined: pc=4, wl=4, sae=4, abort at cycle 6 -> wl_en low and aborted=1 at cycle 7, no sae, no done; abort at cycle 13 (DONE) -> done still pulses, aborted stays 0.
